rhythm_judge: RTL and testbench



---
 rtl/rhythm_pkg.sv | 20 ++
 rtl/rhythm_lane_edge.sv | 21 ++
 rtl/rhythm_judge.sv | 200 ++++++++++++++++++++
 tb/tb_rhythm_judge.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rhythm_pkg.sv
// Shared types for the rhythm judge: judgement codes, note FSM states and
// multiplier width.
package rhythm_pkg;

  localparam int unsigned MULT_W = 4;

  typedef enum logic [1:0] {
    J_NONE,
    J_PERFECT,
    J_GOOD,
    J_MISS
  } judge_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ARMED,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rhythm_lane_edge.sv
// Per-lane press register and rising-edge detect; tracks press every cycle
// (including while paused) so resuming never produces a stale edge.
module rhythm_lane_edge #(
  parameter int unsigned NUM_LANES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] press_i,
  output logic [NUM_LANES-1:0] rise_c_o
);

  logic [NUM_LANES-1:0] press_q;

  always_ff @(posedge clk) begin
    if (reset) press_q <= '0;
    else       press_q <= press_i;
  end

  assign rise_c_o = press_i & ~press_q;

endmodule

// File: rtl/rhythm_judge.sv
// N-lane note queue, timing-window judge, combo/multiplier and saturating score.
// Optional AUTOPLAY_EN adds an autoplay input that auto-judges armed notes perfect.
module rhythm_judge
  import rhythm_pkg::*;
#(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned PERFECT_WIN = 8,
  parameter int unsigned GOOD_WIN    = 32,
  parameter int unsigned SCORE_W     = 14,
  parameter int unsigned COMBO_W     = 14,
  parameter int unsigned COMBO_STEP  = 8,
  parameter int unsigned MULT_MAX    = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             beat_tick,
  input  logic [NUM_LANES-1:0]             note_in,
  input  logic [NUM_LANES-1:0]             press,
  input  logic                             pause,
`ifdef AUTOPLAY_EN
  input  logic                             autoplay,
`endif
  output logic [NUM_LANES*QUEUE_DEPTH-1:0] notes,
  output logic                             hit_perfect,
  output logic                             hit_good,
  output logic                             miss,
  output logic [COMBO_W-1:0]               combo,
  output logic [MULT_W-1:0]                multiplier,
  output logic [SCORE_W-1:0]               score
);

  localparam int unsigned NL        = NUM_LANES;
  localparam int unsigned QW        = NUM_LANES * QUEUE_DEPTH;
  localparam int unsigned TIMER_MAX = GOOD_WIN + 1;
  localparam int unsigned TIMER_W   = $clog2(GOOD_WIN + 2);

  logic [QW-1:0]      queue_q, queue_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  state_e             state_q, state_d;
  logic [NL-1:0]      acc_q, acc_d;
  judge_e             pend_q, pend_d;
  logic               perfect_q, perfect_d, good_q, good_d, miss_q, miss_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [MULT_W-1:0]  mult_q, mult_d;
  logic [SCORE_W-1:0] score_q, score_d;

  logic [NL-1:0]      rise_c, edge_use_c;
  logic [NL-1:0]      mask_c, acc_n_c;
  logic [TIMER_W-1:0] t_eff_c;
  state_e             st_eff_c;
  logic               expiry_c;
  judge_e             new_j_c, emit_c;
  logic [COMBO_W:0]   mult_calc_c;
  logic [4:0]         inc_c;
  logic [SCORE_W:0]   sum_c;

  rhythm_lane_edge #(.NUM_LANES(NUM_LANES)) u_edge (
    .clk      (clk),
    .reset    (reset),
    .press_i  (press),
    .rise_c_o (rise_c)
  );

`ifdef AUTOPLAY_EN
  assign edge_use_c = autoplay ? '0 : rise_c;
`else
  assign edge_use_c = rise_c;
`endif

  always_comb begin
    queue_d     = queue_q;
    timer_d     = timer_q;
    state_d     = state_q;
    acc_d       = acc_q;
    pend_d      = pend_q;
    perfect_d   = 1'b0;
    good_d      = 1'b0;
    miss_d      = 1'b0;
    combo_d     = combo_q;
    mult_d      = mult_q;
    score_d     = score_q;
    mask_c      = queue_q[QW-1 -: NL];
    t_eff_c     = timer_q;
    st_eff_c    = state_q;
    acc_n_c     = acc_q;
    expiry_c    = 1'b0;
    new_j_c     = J_NONE;
    emit_c      = J_NONE;
    mult_calc_c = '0;
    inc_c       = '0;
    sum_c       = '0;

    if (!pause) begin
      // On a tick the judge sees the incoming note with a fresh timer.
      if (beat_tick) begin
        queue_d  = {queue_q[QW-NL-1:0], note_in};
        timer_d  = '0;
        mask_c   = queue_q[QW-NL-1 -: NL];
        t_eff_c  = '0;
        acc_n_c  = '0;
        st_eff_c = (mask_c != '0) ? ST_ARMED : ST_EMPTY;
        expiry_c = (state_q == ST_ARMED);
      end else if (timer_q != TIMER_W'(TIMER_MAX)) begin
        timer_d = timer_q + TIMER_W'(1);
      end

      state_d = st_eff_c;
      case (st_eff_c)
        ST_EMPTY: if (edge_use_c != '0) new_j_c = J_MISS;
        ST_ARMED: begin
`ifdef AUTOPLAY_EN
          if (autoplay && t_eff_c == '0) begin
            new_j_c = J_PERFECT;
            state_d = ST_DONE;
          end
`endif
          acc_n_c = acc_n_c | edge_use_c;
          if ((edge_use_c & ~mask_c) != '0) begin
            new_j_c = J_MISS;
            state_d = ST_DONE;
          end else if (edge_use_c != '0 && acc_n_c == mask_c) begin
            if (t_eff_c <= TIMER_W'(PERFECT_WIN))   new_j_c = J_PERFECT;
            else if (t_eff_c <= TIMER_W'(GOOD_WIN)) new_j_c = J_GOOD;
            else                                    new_j_c = J_MISS;
            state_d = ST_DONE;
          end
        end
        default: ;
      endcase
      acc_d = acc_n_c;

      // Only one pulse per cycle; a second judgement waits one cycle.
      if (pend_q != J_NONE) begin
        emit_c = pend_q;
        pend_d = new_j_c;
      end else if (expiry_c) begin
        emit_c = J_MISS;
        pend_d = new_j_c;
      end else begin
        emit_c = new_j_c;
        pend_d = J_NONE;
      end

      perfect_d = (emit_c == J_PERFECT);
      good_d    = (emit_c == J_GOOD);
      miss_d    = (emit_c == J_MISS);

      if (emit_c == J_MISS) combo_d = '0;
      else if (emit_c != J_NONE && combo_q != '1) combo_d = combo_q + COMBO_W'(1);

      mult_calc_c = ({1'b0, combo_d} / (COMBO_W+1)'(COMBO_STEP)) + (COMBO_W+1)'(1);
      if (mult_calc_c > (COMBO_W+1)'(MULT_MAX)) mult_d = MULT_W'(MULT_MAX);
      else                                      mult_d = MULT_W'(mult_calc_c);

      if (emit_c == J_PERFECT || emit_c == J_GOOD) begin
        inc_c   = perfect_d ? {mult_d, 1'b0} : {1'b0, mult_d};
        sum_c   = {1'b0, score_q} + (SCORE_W+1)'(inc_c);
        score_d = sum_c[SCORE_W] ? '1 : sum_c[SCORE_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      queue_q   <= '0;
      timer_q   <= '0;
      state_q   <= ST_EMPTY;
      acc_q     <= '0;
      pend_q    <= J_NONE;
      perfect_q <= 1'b0;
      good_q    <= 1'b0;
      miss_q    <= 1'b0;
      combo_q   <= '0;
      mult_q    <= MULT_W'(1);
      score_q   <= '0;
    end else begin
      queue_q   <= queue_d;
      timer_q   <= timer_d;
      state_q   <= state_d;
      acc_q     <= acc_d;
      pend_q    <= pend_d;
      perfect_q <= perfect_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      combo_q   <= combo_d;
      mult_q    <= mult_d;
      score_q   <= score_d;
    end
  end

  assign notes       = queue_q;
  assign hit_perfect = perfect_q;
  assign hit_good    = good_q;
  assign miss        = miss_q;
  assign combo       = combo_q;
  assign multiplier  = mult_q;
  assign score       = score_q;

endmodule

// File: tb/tb_rhythm_judge.sv
// Directed bench for rhythm_judge: hits, chords, expiry, wrong lanes,
// multiplier steps, pause, window boundaries and deferred judgements.
module tb_rhythm_judge;

  logic        clk = 1'b0;
  logic        reset;
  logic        beat_tick;
  logic [3:0]  note_in;
  logic [3:0]  press;
  logic        pause;
  logic [15:0] notes;
  logic        hit_perfect, hit_good, miss;
  logic [13:0] combo;
  logic [3:0]  multiplier;
  logic [13:0] score;

  int checks   = 0;
  int failures = 0;
  int exp_score;
  int exp_mult;

  always #5 clk = ~clk;

  rhythm_judge dut (
    .clk         (clk),
    .reset       (reset),
    .beat_tick   (beat_tick),
    .note_in     (note_in),
    .press       (press),
    .pause       (pause),
`ifdef AUTOPLAY_EN
    .autoplay    (1'b0),
`endif
    .notes       (notes),
    .hit_perfect (hit_perfect),
    .hit_good    (hit_good),
    .miss        (miss),
    .combo       (combo),
    .multiplier  (multiplier),
    .score       (score)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic tick(input logic [3:0] m);
    beat_tick = 1'b1;
    note_in   = m;
    cyc();
    beat_tick = 1'b0;
    note_in   = '0;
  endtask

  task automatic chk_state(input string tag, input int sc, input int co, input int mu);
    chk({tag, "_score"}, 32'(score), 32'(sc));
    chk({tag, "_combo"}, 32'(combo), 32'(co));
    chk({tag, "_mult"},  32'(multiplier), 32'(mu));
  endtask

  initial begin
    reset = 1'b1; beat_tick = 1'b0; note_in = '0; press = '0; pause = 1'b0;
    cyc(2);
    reset = 1'b0;
    chk("rst_notes", 32'(notes), 32'h0);
    chk("rst_pulses", 32'({hit_perfect, hit_good, miss}), 32'h0);
    chk_state("rst", 0, 0, 1);

    // single note, perfect at timer 2
    tick(4'b0001); tick(4'b0000); tick(4'b0000);
    chk("t1_queue", 32'(notes), 32'h0100);
    tick(4'b0000);
    chk("t1_active", 32'(notes), 32'h1000);
    cyc(2);
    press = 4'b0001; cyc();
    chk("t1_perfect", 32'(hit_perfect), 32'h1);
    chk_state("t1", 2, 1, 1);
    press = '0; cyc();
    chk("t1_pulse_len", 32'(hit_perfect), 32'h0);

    // chord: lane0 at timer 5, lane2 at timer 20 -> good
    tick(4'b0101); tick(4'b0000); tick(4'b0000); tick(4'b0000);
    chk("t2_no_expiry", 32'(miss), 32'h0);
    cyc(5);
    press = 4'b0001; cyc();
    chk("t2_partial", 32'({hit_perfect, hit_good, miss}), 32'h0);
    cyc(14);
    press = 4'b0101; cyc();
    chk("t2_good", 32'({hit_perfect, hit_good, miss}), 32'b010);
    chk_state("t2", 3, 2, 1);
    press = '0; cyc();

    // unpressed note expires on next tick
    tick(4'b0010); tick(4'b0000); tick(4'b0000); tick(4'b0000);
    cyc(3);
    tick(4'b0000);
    chk("t3_expiry", 32'({hit_perfect, hit_good, miss}), 32'b001);
    chk_state("t3", 3, 0, 1);

    // wrong lane -> miss, later correct lane ignored
    tick(4'b0001); tick(4'b0000); tick(4'b0000); tick(4'b0000);
    cyc();
    press = 4'b1000; cyc();
    chk("t4_wrong", 32'({hit_perfect, hit_good, miss}), 32'b001);
    press = '0; cyc();
    press = 4'b0001; cyc();
    chk("t4_ignored", 32'({hit_perfect, hit_good, miss}), 32'b000);
    chk_state("t4", 3, 0, 1);
    press = '0;

    // 16 consecutive perfects, multiplier steps at 8 and 16
    tick(4'b0001); tick(4'b0001); tick(4'b0001);
    exp_score = 3;
    for (int k = 1; k <= 16; k++) begin
      tick(4'b0001);
      cyc();
      press = 4'b0001; cyc();
      exp_mult = (k < 8) ? 1 : (k < 16) ? 2 : 3;
      exp_score += 2 * exp_mult;
      chk("t5_perfect", 32'(hit_perfect), 32'h1);
      chk_state("t5", exp_score, k, exp_mult);
      press = '0; cyc();
    end
    chk("t5_final_score", 32'(score), 32'd55);

    // pause with press held; ticks ignored; timer frozen
    tick(4'b0000);
    cyc(2);
    pause = 1'b1; press = 4'b0001;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin beat_tick = 1'b1; note_in = 4'b0010; end
      cyc();
      beat_tick = 1'b0; note_in = '0;
      if (i % 10 == 0) begin
        chk("t6_pause_pulses", 32'({hit_perfect, hit_good, miss}), 32'h0);
        chk("t6_pause_notes", 32'(notes), 32'h1110);
      end
    end
    pause = 1'b0; cyc();
    chk("t6_resume_no_edge", 32'({hit_perfect, hit_good, miss}), 32'h0);
    press = '0; cyc();
    press = 4'b0001; cyc();
    chk("t6_timer_frozen", 32'({hit_perfect, hit_good, miss}), 32'b100);
    chk_state("t6", 61, 17, 3);
    press = '0; cyc();

    // window boundaries: perfect at 8, miss at saturated 33, good at 32
    tick(4'b0000);
    cyc(8);
    press = 4'b0001; cyc();
    chk("t7_perfect_edge", 32'({hit_perfect, hit_good, miss}), 32'b100);
    chk_state("t7a", 67, 18, 3);
    press = '0; cyc();
    tick(4'b0000);
    cyc(40);
    press = 4'b0001; cyc();
    chk("t7_late_miss", 32'({hit_perfect, hit_good, miss}), 32'b001);
    chk_state("t7b", 67, 0, 1);
    press = '0; cyc();
    tick(4'b0100); tick(4'b0000); tick(4'b0000); tick(4'b0000);
    cyc(32);
    press = 4'b0100; cyc();
    chk("t7_good_edge", 32'({hit_perfect, hit_good, miss}), 32'b010);
    chk_state("t7c", 68, 1, 1);
    press = '0; cyc();

    // expiry and incoming judgement in one tick: incoming deferred a cycle
    tick(4'b0010); tick(4'b0001); tick(4'b0000); tick(4'b0000);
    cyc();
    beat_tick = 1'b1; press = 4'b0001; cyc();
    beat_tick = 1'b0;
    chk("t8_expiry", 32'({hit_perfect, hit_good, miss}), 32'b001);
    chk_state("t8a", 68, 0, 1);
    cyc();
    chk("t8_deferred", 32'({hit_perfect, hit_good, miss}), 32'b100);
    chk_state("t8b", 70, 1, 1);
    press = '0; cyc();
    chk("t8_quiet", 32'({hit_perfect, hit_good, miss}), 32'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
